// File: rtl/pulse_timer.sv
// Phase-width timer for the WS2812 decode path: counts enable ticks per line phase,
// publishes each completed phase width on the next edge and saturates at SAT_COUNT.
// Optional latch/reset (long low) detection enabled by PULSE_TIMER_RESET_DET_EN.

package pipeline_types;
  typedef struct packed {
    logic rising;
    logic falling;
  } control_path_t;
endpackage

module pulse_timer #(
  parameter int WIDTH       = 10,
  parameter int SAT_COUNT   = 512,
  parameter int RESET_TICKS = 400
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_count_enable,
  input  pipeline_types::control_path_t i_control,
  output logic [WIDTH-1:0]              o_count,
  output logic [WIDTH-1:0]              o_width,
  output logic                          o_width_valid,
  output logic                          o_width_is_high,
  output logic                          o_saturated,
  output logic                          o_glitch,
  output logic                          o_reset_det
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(SAT_COUNT);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("pulse_timer: WIDTH out of range");
  end
  if (SAT_COUNT < 1 || SAT_COUNT > (1 << WIDTH) - 1) begin : g_bad_sat
    $error("pulse_timer: SAT_COUNT out of range");
  end
  if (RESET_TICKS < 1 || RESET_TICKS > SAT_COUNT) begin : g_bad_rst
    $error("pulse_timer: RESET_TICKS out of range");
  end

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_width;
  logic             r_width_valid;
  logic             r_width_is_high;
  logic             r_glitch;
  logic             r_level;
  logic             r_primed;

  logic w_edge;
  logic w_both;
  logic w_at_sat;

  assign w_edge   = i_control.rising | i_control.falling;
  assign w_both   = i_control.rising & i_control.falling;
  assign w_at_sat = (r_count == SAT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count         <= '0;
      r_width         <= '0;
      r_width_valid   <= 1'b0;
      r_width_is_high <= 1'b0;
      r_glitch        <= 1'b0;
      r_level         <= 1'b0;
      r_primed        <= 1'b0;
    end else begin
      r_width_valid <= 1'b0;
      r_glitch      <= 1'b0;
      if (w_edge) begin
        // Edge wins over any enable in the same cycle.
        r_count <= '0;
        if (w_both) begin
          r_glitch <= 1'b1;
        end else begin
          // The phase before the first edge was not fully seen, so it is not published.
          if (r_primed) begin
            r_width         <= r_count;
            r_width_is_high <= i_control.falling;
            r_width_valid   <= 1'b1;
          end
          r_level  <= i_control.rising;
          r_primed <= 1'b1;
        end
      end else if (i_count_enable && !w_at_sat) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef PULSE_TIMER_RESET_DET_EN
  localparam logic [WIDTH-1:0] RT_M1 = WIDTH'(RESET_TICKS - 1);

  logic r_reset_det;

  // RESET_TICKS <= SAT_COUNT, so the step from RT_M1 is never blocked by saturation.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_reset_det <= 1'b0;
    else            r_reset_det <= !w_edge && i_count_enable && !r_level && (r_count == RT_M1);
  end

  assign o_reset_det = r_reset_det;
`else
  assign o_reset_det = 1'b0;
`endif

  assign o_count         = r_count;
  assign o_width         = r_width;
  assign o_width_valid   = r_width_valid;
  assign o_width_is_high = r_width_is_high;
  assign o_saturated     = w_at_sat;
  assign o_glitch        = r_glitch;

endmodule

// File: tb/tb_pulse_timer.sv
// Directed self-checking bench for pulse_timer with default parameters
// (WIDTH 10, SAT_COUNT 512, RESET_TICKS 400).

module tb_pulse_timer;

  logic                          i_clk;
  logic                          i_reset_n;
  logic                          i_count_enable;
  pipeline_types::control_path_t i_control;
  logic [9:0]                    o_count;
  logic [9:0]                    o_width;
  logic                          o_width_valid;
  logic                          o_width_is_high;
  logic                          o_saturated;
  logic                          o_glitch;
  logic                          o_reset_det;

  int n_checks;
  int n_fail;

  pulse_timer #(.WIDTH(10), .SAT_COUNT(512), .RESET_TICKS(400)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_count_enable  (i_count_enable),
    .i_control       (i_control),
    .o_count         (o_count),
    .o_width         (o_width),
    .o_width_valid   (o_width_valid),
    .o_width_is_high (o_width_is_high),
    .o_saturated     (o_saturated),
    .o_glitch        (o_glitch),
    .o_reset_det     (o_reset_det)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs set before cyc() are sampled at the next rising edge; outputs are read 1 ns later.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic rise, input logic fall);
    i_count_enable    = en;
    i_control.rising  = rise;
    i_control.falling = fall;
  endtask

  task automatic enables(input int n);
    drive(1'b1, 1'b0, 1'b0);
    repeat (n) cyc();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #12;
    n_checks++;
    if ({o_count, o_width, o_width_valid, o_width_is_high, o_saturated, o_glitch, o_reset_det} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d width=%0d valid=%b high=%b sat=%b glitch=%b rdet=%b, want all 0",
               o_count, o_width, o_width_valid, o_width_is_high, o_saturated, o_glitch, o_reset_det);
    end
    i_reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_width_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_edge_valid: got %b want 0", o_width_valid);
    end
    enables(30);
    n_checks++;
    if (o_count !== 10'd30) begin
      n_fail++; $display("FAIL basic_count: got %0d want 30", o_count);
    end
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high, o_count} !== {1'b1, 10'd30, 1'b1, 10'd0}) begin
      n_fail++;
      $display("FAIL basic_publish: valid=%b width=%0d high=%b count=%0d, want 1/30/1/0",
               o_width_valid, o_width, o_width_is_high, o_count);
    end
    cyc();
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high} !== {1'b0, 10'd30, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_hold: valid=%b width=%0d high=%b, want 0/30/1", o_width_valid, o_width, o_width_is_high);
    end
  endtask

  // Line is low with count 1 (from the hold cycle? no: enable was 0) -> count 0 here.
  task automatic test_reset_det();
    int pulses;
    logic [9:0] cnt_at;
    pulses = 0;
    cnt_at = '0;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 450; i++) begin
      cyc();
      if (o_reset_det === 1'b1) begin
        pulses++;
        cnt_at = o_count;
      end
    end
    drive(1'b0, 1'b0, 1'b0);
`ifdef PULSE_TIMER_RESET_DET_EN
    n_checks++;
    if (pulses != 1 || cnt_at !== 10'd400) begin
      n_fail++; $display("FAIL reset_det: pulses=%0d at count %0d, want 1 at 400", pulses, cnt_at);
    end
`else
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_det_off: pulses=%0d want 0", pulses);
    end
`endif
  endtask

  task automatic test_saturate();
    n_checks++;
    if (o_saturated !== 1'b0 || o_count !== 10'd450) begin
      n_fail++; $display("FAIL pre_sat: count=%0d sat=%b want 450/0", o_count, o_saturated);
    end
    enables(150);
    n_checks++;
    if (o_count !== 10'd512 || o_saturated !== 1'b1) begin
      n_fail++; $display("FAIL saturate: count=%0d sat=%b want 512/1", o_count, o_saturated);
    end
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high, o_saturated} !== {1'b1, 10'd512, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_publish: valid=%b width=%0d high=%b sat=%b, want 1/512/0/0",
               o_width_valid, o_width, o_width_is_high, o_saturated);
    end
  endtask

  task automatic test_edge_priority();
    enables(7);
    drive(1'b1, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_count, o_width_valid, o_width, o_width_is_high} !== {10'd0, 1'b1, 10'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL edge_priority: count=%0d valid=%b width=%0d high=%b, want 0/1/7/1",
               o_count, o_width_valid, o_width, o_width_is_high);
    end
  endtask

  task automatic test_glitch();
    enables(3);
    drive(1'b0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_glitch, o_width_valid, o_count, o_width} !== {1'b1, 1'b0, 10'd0, 10'd7}) begin
      n_fail++;
      $display("FAIL glitch: glitch=%b valid=%b count=%0d width=%0d, want 1/0/0/7",
               o_glitch, o_width_valid, o_count, o_width);
    end
    cyc();
    n_checks++;
    if (o_glitch !== 1'b0) begin
      n_fail++; $display("FAIL glitch_strobe: got %b want 0", o_glitch);
    end
    enables(5);
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high} !== {1'b1, 10'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL after_glitch: valid=%b width=%0d high=%b, want 1/5/0", o_width_valid, o_width, o_width_is_high);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high} !== {1'b1, 10'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_back: valid=%b width=%0d high=%b, want 1/0/0", o_width_valid, o_width, o_width_is_high);
    end
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high} !== {1'b1, 10'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_back_tick: valid=%b width=%0d high=%b, want 1/1/0", o_width_valid, o_width, o_width_is_high);
    end
  endtask

  task automatic test_reset_mid();
    enables(20);
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    enables(100);
    n_checks++;
    if (o_count !== 10'd100 || o_width !== 10'd20) begin
      n_fail++; $display("FAIL pre_reset: count=%0d width=%0d want 100/20", o_count, o_width);
    end
    #2 i_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_count, o_width, o_width_valid, o_width_is_high, o_saturated, o_glitch, o_reset_det} !== 25'd0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d width=%0d valid=%b high=%b sat=%b glitch=%b rdet=%b, want all 0",
               o_count, o_width, o_width_valid, o_width_is_high, o_saturated, o_glitch, o_reset_det);
    end
    cyc();
    i_reset_n = 1'b1;
    cyc();
    drive(1'b0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (o_width_valid !== 1'b0 || o_width !== 10'd0) begin
      n_fail++; $display("FAIL post_reset_edge: valid=%b width=%0d want 0/0", o_width_valid, o_width);
    end
    enables(4);
    drive(1'b0, 1'b0, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({o_width_valid, o_width, o_width_is_high} !== {1'b1, 10'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_publish: valid=%b width=%0d high=%b, want 1/4/1", o_width_valid, o_width, o_width_is_high);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_reset_det();
    test_saturate();
    test_edge_priority();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_timer.md
# pulse_timer

Parametrised successor to the fixed 10-bit edge counter in the WS2812 decode path. Measures the duration of each high and low phase of the data line in count-enable ticks. On every edge it publishes the completed phase width with a valid strobe and a phase flag, and it saturates instead of wrapping. Optionally it detects the WS2812 latch/reset (long low) condition. It sits between the edge detector and the bit decoder.

## Interface
Parameters:
- WIDTH, 10, counter and width-output bit width; legal range 4..16.
- SAT_COUNT, 512, saturation value of the running count; legal range 1..2**WIDTH-1.
- RESET_TICKS, 400, low-phase length that flags a line reset; legal range 1..SAT_COUNT.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_count_enable  in  1  tick strobe; the count advances only on cycles where it is high.
- i_control  in  pipeline_types::control_path_t  edge flags from the edge detector; uses fields rising and falling.
- o_count  out  WIDTH  running count of the current phase (registered).
- o_width  out  WIDTH  width of the most recently completed phase.
- o_width_valid  out  1  one-cycle strobe marking a new o_width.
- o_width_is_high  out  1  1 means o_width is a high phase; 0 means a low phase.
- o_saturated  out  1  high while o_count == SAT_COUNT.
- o_glitch  out  1  one-cycle strobe when rising and falling are asserted in the same cycle.
- o_reset_det  out  1  one-cycle strobe when a low phase reaches RESET_TICKS.

## Operation
- State:
  - r_count (WIDTH bits).
  - r_level: last edge seen, 1 means line high.
  - r_primed: set by the first edge after reset.
- Edge = rising OR falling. Edge priority is absolute: on an edge cycle r_count becomes 0 and any enable in that cycle is discarded.
- Without an edge: if i_count_enable and r_count != SAT_COUNT, r_count increments by 1. At SAT_COUNT it holds; it never wraps.
- Rising only:
  - if r_primed, capture o_width = r_count and o_width_is_high = 0, and pulse o_width_valid;
  - r_level = 1, r_primed = 1.
- Falling only: same as rising only, but o_width_is_high = 1 and r_level = 0.
- Rising and falling together:
  - r_count cleared, o_glitch pulses;
  - no capture, o_width_valid stays 0;
  - r_level and r_primed unchanged.
- First edge after reset: clears the count and sets r_primed, but publishes nothing, because the preceding phase was not fully observed.
- A saturated width is published as SAT_COUNT. The consumer treats that value as "at least SAT_COUNT".
- o_width and o_width_is_high hold their values between strobes.

## Timing
- Reset values:
  - o_count 0, o_width 0, o_width_valid 0, o_width_is_high 0;
  - o_saturated 0, o_glitch 0, o_reset_det 0;
  - r_level 0, r_primed 0.
- o_count is r_count, so an increment is visible the cycle after the enable.
- o_width, o_width_valid, o_width_is_high and o_glitch are registered with 1-cycle latency from the edge cycle. o_width equals o_count as it was during the edge cycle.
- o_saturated is decoded combinationally from r_count.
- Back-to-back edges on consecutive cycles are legal. The second one publishes width 0, or the single-tick count if an enable landed in between.
- Asserting reset mid-phase returns all state to reset values immediately. The next edge is then treated as a first edge.

## Configuration
- PULSE_TIMER_RESET_DET_EN defined:
  - o_reset_det pulses for one cycle, registered, in the cycle after r_count steps from RESET_TICKS-1 to RESET_TICKS while r_level == 0;
  - this fires once per low phase, is independent of r_primed, and fires even when RESET_TICKS == SAT_COUNT.
- PULSE_TIMER_RESET_DET_EN undefined:
  - o_reset_det is tied to 0 and RESET_TICKS is unused;
  - no detection logic is generated.

## Test plan
- Reset, then rising edge, 30 enables, falling edge: no valid on the rising edge. One cycle after the falling edge: o_width_valid = 1, o_width = 30, o_width_is_high = 1.
- Continuing low, 600 enables with SAT_COUNT = 512: o_count stops at 512 and o_saturated = 1. Then rising edge: o_width = 512, o_width_is_high = 0.
- Edge and enable in the same cycle with o_count = 7: o_count becomes 0, not 1. Published o_width = 7.
- Rising and falling asserted together: o_glitch strobes for 1 cycle, no o_width_valid, o_count = 0, and the next single edge publishes normally.
- With the macro defined and RESET_TICKS = 400, after a falling edge: o_reset_det strobes exactly once as o_count reaches 400. The same stimulus with the macro undefined leaves o_reset_det at 0.
- i_reset_n pulsed low mid-phase at o_count = 100: all outputs return to 0 asynchronously. The following edge publishes nothing.
